// File: rtl/subtree_arb_pkg.sv
// subtree_arb_pkg: shared state encoding and default sizing for the subtree round-robin arbiter
package subtree_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_e;
    localparam int NUM_REQ_DEFAULT = 10;
    localparam int MAX_HOLD_DEFAULT = 16;
endpackage

// File: rtl/subtree_rr_arbiter_if.sv
// subtree_rr_arbiter_if: request/done/grant bundle between a child instance array and its arbiter
interface subtree_rr_arbiter_if
    import subtree_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
);
    localparam int IDX_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] done_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               busy_o;
    logic               timeout_o;
    logic [7:0]         timeout_cnt_o;
    modport master (
        output req_i, done_i,
        input  gnt_o, gnt_idx_o, busy_o, timeout_o, timeout_cnt_o
    );
    modport slave (
        input  req_i, done_i,
        output gnt_o, gnt_idx_o, busy_o, timeout_o, timeout_cnt_o
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority find-first starting at ptr and wrapping past NUM_REQ-1
module rr_pick
    import subtree_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IDX_W = $clog2(NUM_REQ);
    logic [IDX_W:0] sum;
    logic [IDX_W:0] pos;
    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        valid = |req;
        idx = '0;
        sum = '0;
        pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            pos = (sum >= (IDX_W + 1)'(NUM_REQ)) ? sum - (IDX_W + 1)'(NUM_REQ) : sum;
            idx = req[pos[IDX_W-1:0]] ? pos[IDX_W-1:0] : idx;
        end
    end
endmodule

// File: rtl/subtree_rr_arbiter.sv
// subtree_rr_arbiter: round-robin grant of one resource slot among a node's child instances,
// released on the grantee's done or a hold timeout, with a saturating timeout count.
module subtree_rr_arbiter
    import subtree_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEFAULT,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input logic                 clk,
    input logic                 rst_n,
    subtree_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_GRANT   = GRANT;
    localparam logic [1:0] S_RELEASE = RELEASE;
    logic [1:0]         state;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   cnt;
    logic               timeout;
    logic [7:0]         timeout_cnt;
    logic               done_hit;
    logic               hold_expired;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req_i),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Only the current grantee's done matters; done wins over a simultaneous expiry.
    assign done_hit     = bus.done_i[gnt_idx];
    assign hold_expired = cnt == CNT_W'(MAX_HOLD - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout     <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state   <= S_GRANT;
                        gnt     <= NUM_REQ'(1) << pick_idx;
                        gnt_idx <= pick_idx;
                        cnt     <= '0;
                    end
                end
                S_GRANT: begin
                    cnt <= cnt + 1'b1;
                    if (done_hit || hold_expired) begin
                        state <= S_RELEASE;
                        gnt   <= '0;
                    end
                    if (!done_hit && hold_expired) begin
                        timeout     <= 1'b1;
                        timeout_cnt <= timeout_cnt + {7'd0, timeout_cnt != 8'hFF};
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                    ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt_o         = gnt;
    assign bus.gnt_idx_o     = gnt_idx;
    assign bus.busy_o        = state == S_GRANT;
    assign bus.timeout_o     = timeout;
    assign bus.timeout_cnt_o = timeout_cnt;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    assert property (@(posedge clk) disable iff (!rst_n) (gnt != '0) == (state == S_GRANT));
endmodule

// File: tb/tb_subtree_rr_arbiter.sv
// tb_subtree_rr_arbiter: directed stimulus with a queue-based scoreboard checked by a separate monitor
module tb_subtree_rr_arbiter;
    localparam int N  = 10;
    localparam int MH = 16;
    typedef struct {int kind; int a; int b; int c;} ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int start = 0;
    logic prev_busy = 1'b0;
    ev_t q[$];

    subtree_rr_arbiter_if #(.NUM_REQ(N)) bus();
    subtree_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) step();
    endtask

    function automatic void exp_gnt(int idx, int c);
        q.push_back('{0, idx, c, 0});
    endfunction

    function automatic void exp_rel(int len, int to, int tc);
        q.push_back('{1, len, to, tc});
    endfunction

    // Grant start: index, one-hot vector and cycle; grant end: length, timeout pulse, count.
    always @(negedge clk) begin
        ev_t e;
        check("onehot0", int'($onehot0(bus.gnt_o)), 1);
        check("gnt_vs_busy", int'(bus.gnt_o != '0), int'(bus.busy_o));
        if (bus.busy_o && !prev_busy) begin
            start = cyc;
            if (q.size() == 0) check("unexpected_grant", int'(bus.gnt_idx_o), -1);
            else begin
                e = q.pop_front();
                check("grant_kind", 0, e.kind);
                check("gnt_idx", int'(bus.gnt_idx_o), e.a);
                check("gnt_vec", int'(bus.gnt_o), 1 << e.a);
                check("gnt_cycle", cyc, e.b);
            end
        end else if (!bus.busy_o && prev_busy) begin
            if (q.size() == 0) check("unexpected_release", cyc, -1);
            else begin
                e = q.pop_front();
                check("release_kind", 1, e.kind);
                check("hold_len", cyc - start, e.a);
                check("timeout_pulse", int'(bus.timeout_o), e.b);
                check("timeout_cnt", int'(bus.timeout_cnt_o), e.c);
            end
        end else if (bus.timeout_o) begin
            check("stray_timeout", 1, 0);
        end
        prev_busy = bus.busy_o;
    end

    initial begin
        #1000000;
        mismatched++;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        bus.req_i = '0;
        bus.done_i = '0;
        for (int i = 0; i < 2; i++) begin
            bus.req_i = N'($urandom);
            bus.done_i = N'($urandom);
            step();
        end
        check("rst_gnt", int'(bus.gnt_o), 0);
        check("rst_idx", int'(bus.gnt_idx_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_timeout", int'(bus.timeout_o), 0);
        check("rst_tcnt", int'(bus.timeout_cnt_o), 0);
        rst_n = 1'b1;
        bus.req_i = '0;
        bus.done_i = '0;
        repeat (3) step();
        check("idle_no_req", int'(bus.busy_o), 0);
        t = cyc;
        bus.req_i = N'(1) << 3;
        exp_gnt(3, t + 1);
        exp_rel(4, 0, 0);
        wait_to(t + 4);
        bus.done_i = N'(1) << 3;
        bus.req_i = '0;
        step();
        bus.done_i = '0;
        step();
        check("idle_after_done", int'(bus.busy_o), 0);
        check("keep_last_idx", int'(bus.gnt_idx_o), 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        t = cyc;
        bus.req_i = '1;
        for (int k = 0; k <= N; k++) begin
            exp_gnt(k % N, t + 1 + 3 * k);
            exp_rel(1, 0, 0);
        end
        for (int k = 0; k <= N; k++) begin
            wait_to(t + 1 + 3 * k);
            bus.done_i = N'(1) << (k % N);
            if (k == N) bus.req_i = '0;
            step();
            bus.done_i = '0;
        end
        repeat (3) step();
        t = cyc;
        bus.req_i = N'(1) << 5;
        exp_gnt(5, t + 1);
        exp_rel(MH, 1, 1);
        wait_to(t + 1);
        bus.req_i = '0;
        wait_to(t + MH + 3);
        t = cyc;
        bus.req_i = N'(1) << 2;
        exp_gnt(2, t + 1);
        exp_rel(MH, 0, 1);
        wait_to(t + 1);
        bus.req_i = '0;
        wait_to(t + 3);
        bus.done_i = N'(1) << 7;
        step();
        bus.done_i = '0;
        wait_to(t + MH);
        bus.done_i = N'(1) << 2;
        step();
        bus.done_i = '0;
        wait_to(t + MH + 3);
        t = cyc;
        bus.req_i = N'(1);
        for (int k = 0; k < 256; k++) begin
            exp_gnt(0, t + 1 + (MH + 2) * k);
            exp_rel(MH, 1, (k + 2 > 255) ? 255 : k + 2);
        end
        wait_to(t + 1 + (MH + 2) * 255);
        bus.req_i = '0;
        wait_to(t + 1 + (MH + 2) * 255 + MH + 3);
        check("tcnt_saturated", int'(bus.timeout_cnt_o), 255);
        t = cyc;
        bus.req_i = N'(1) << 5;
        exp_gnt(5, t + 1);
        exp_rel(1, 0, 255);
        wait_to(t + 1);
        bus.done_i = N'(1) << 5;
        bus.req_i = '0;
        step();
        bus.done_i = '0;
        wait_to(t + 4);
        t = cyc;
        bus.req_i = N'(1) << 6;
        exp_gnt(6, t + 1);
        exp_rel(3, 0, 0);
        wait_to(t + 3);
        rst_n = 1'b0;
        bus.req_i = '0;
        step();
        check("midgrant_rst_gnt", int'(bus.gnt_o), 0);
        check("midgrant_rst_busy", int'(bus.busy_o), 0);
        check("midgrant_rst_tcnt", int'(bus.timeout_cnt_o), 0);
        rst_n = 1'b1;
        t = cyc;
        bus.req_i = (N'(1) << 6) | (N'(1) << 1);
        exp_gnt(1, t + 1);
        exp_rel(1, 0, 0);
        exp_gnt(6, t + 4);
        exp_rel(1, 0, 0);
        wait_to(t + 1);
        bus.done_i = N'(1) << 1;
        bus.req_i = N'(1) << 6;
        step();
        bus.done_i = '0;
        wait_to(t + 4);
        bus.done_i = N'(1) << 6;
        bus.req_i = '0;
        step();
        bus.done_i = '0;
        wait_to(t + 8);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
